// File: rtl/rx_pkg.sv
// Shared types for the UART receive path (control FSM and rx_datapath).
package rx_pkg;

    // Receive FSM states. PARITY is only reachable when parity checking is built in.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PARITY
    } rx_state_t;

    // Each field is {en, clr} for one datapath element.
    typedef struct packed {
        logic [1:0] clk_ctrl;
        logic [1:0] sample_ctrl;
        logic [1:0] bit_ctrl;
        logic [1:0] data_ctrl;
    } controlPoints_t;

    localparam logic [1:0] CTRL_NONE = 2'b00;
    localparam logic [1:0] CTRL_CLR  = 2'b01;
    localparam logic [1:0] CTRL_EN   = 2'b10;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Control/status bundle between uart_rx_ctrl and rx_datapath/consumer.
// rx_perr only exists when UART_RX_PARITY_EN is defined.
interface uart_rx_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    import rx_pkg::*;

    localparam int unsigned BCW = $clog2(DATA_WIDTH);

    logic           sample;
    logic           mid_bit;
    logic [BCW-1:0] bit_count;
    controlPoints_t cPts;
    logic           rx_valid;
    logic           rx_ferr;
    logic           rx_busy;
`ifdef UART_RX_PARITY_EN
    logic           rx_perr;

    modport master (
        input  sample, mid_bit, bit_count,
        output cPts, rx_valid, rx_ferr, rx_busy, rx_perr
    );
    modport slave (
        output sample, mid_bit, bit_count,
        input  cPts, rx_valid, rx_ferr, rx_busy, rx_perr
    );
`else
    modport master (
        input  sample, mid_bit, bit_count,
        output cPts, rx_valid, rx_ferr, rx_busy
    );
    modport slave (
        output sample, mid_bit, bit_count,
        input  cPts, rx_valid, rx_ferr, rx_busy
    );
`endif

endinterface

// File: rtl/uart_rx_ctrl_synchronizer.sv
// N-flop synchroniser for an asynchronous level; all flops reset to 1 (line idle).
module synchronizer #(
    parameter int unsigned N = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_sync;

    // Shift the raw input through N flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control FSM: synchronises rx_in, detects the start bit, drives the
// datapath control points and emits frame-complete / error strobes.
// Optional parity checking is built in when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl
    import rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           rx_in,
    output logic           rx_sync,
    uart_rx_ctrl_if.master bus
);

    localparam int unsigned CLKS_PER_SAMPLE = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned BCW = $clog2(DATA_WIDTH);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
        $error("OVERSAMPLE must be a power of 2 and >= 4");
    end
    if (CLKS_PER_SAMPLE < 2) begin : g_bad_clk_ratio
        $error("CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end

    rx_state_t      r_state;
    rx_state_t      w_state_next;
    controlPoints_t w_cpts;
    logic           w_tick;
    logic           w_last_bit;
    logic           w_stop_tick;
    logic           w_perr_flag;
    logic           r_valid;
    logic           r_ferr;

    synchronizer #(
        .N(2)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .i_d  (rx_in),
        .o_q  (rx_sync)
    );

    // Mid-bit strobe: fires once per bit period at the centre of the bit.
    assign w_tick      = bus.sample & bus.mid_bit;
    assign w_last_bit  = (bus.bit_count == LAST_BIT);
    assign w_stop_tick = (r_state == STOP) & w_tick;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath control points.
    always_comb begin
        w_state_next = r_state;
        w_cpts       = '0;
        case (r_state)
            IDLE: begin
                w_cpts.clk_ctrl    = CTRL_CLR;
                w_cpts.sample_ctrl = CTRL_CLR;
                w_cpts.bit_ctrl    = CTRL_CLR;
                if (!rx_sync) begin
                    w_cpts.data_ctrl = CTRL_CLR;
                    w_state_next     = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_cpts.data_ctrl = CTRL_EN;
                    w_cpts.bit_ctrl  = w_last_bit ? CTRL_CLR : CTRL_EN;
                    if (w_last_bit) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                // Leave mid-stop-bit so a back-to-back start edge is not missed.
                if (w_tick) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        // Bit-timing counters free-run in every active state.
        if (r_state != IDLE) begin
            w_cpts.clk_ctrl    = bus.sample ? CTRL_CLR : CTRL_EN;
            w_cpts.sample_ctrl = bus.sample ? CTRL_EN : CTRL_NONE;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_parity;
    logic r_perr_flag;
    logic r_perr;

    // Running parity of received data bits and latched parity mismatch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_parity    <= 1'b0;
            r_perr_flag <= 1'b0;
        end else if (r_state == IDLE && !rx_sync) begin
            r_parity    <= 1'b0;
            r_perr_flag <= 1'b0;
        end else if (r_state == DATA && w_tick) begin
            r_parity <= r_parity ^ rx_sync;
        end else if (r_state == PARITY && w_tick) begin
            r_perr_flag <= rx_sync ^ r_parity ^ PARITY_ODD;
        end
    end

    // Parity error strobe is reported together with the stop-bit outcome.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_stop_tick & r_perr_flag;
        end
    end

    assign w_perr_flag = r_perr_flag;
    assign bus.rx_perr = r_perr;
`else
    assign w_perr_flag = 1'b0;
`endif

    // Registered completion strobes, decided on the stop-bit tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= w_stop_tick & rx_sync & ~w_perr_flag;
            r_ferr  <= w_stop_tick & ~rx_sync;
        end
    end

    assign bus.cPts     = w_cpts;
    assign bus.rx_valid = r_valid;
    assign bus.rx_ferr  = r_ferr;
    assign bus.rx_busy  = (r_state != IDLE);

endmodule
